// File: rtl/bmp_frame_writer.sv
// ---------------------------------------------------------------------------
// bmp_frame_writer
//
// Accepts a raster-order stream of pixel beats (PPB pixels of CH bytes each)
// and turns every beat into one byte-addressed memory write laid out as a
// BMP pixel array. Rows are placed bottom-up when FLIP=1 and top-down when
// FLIP=0. Each row starts on a 4-byte aligned stride after the HDR_BYTES
// header. The channel order inside every pixel is reversed (RGB -> BGR).
// Row padding bytes are never written.
//
// Ports
//   HCLK       in   clock, all state changes on the rising edge
//   HRESET     in   synchronous active-high reset
//   start      in   single-cycle frame start request (honoured only in IDLE)
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid && in_ready
//   in_data    in   PPB*CH*8 bits, pixel p at [(p+1)*CH*8-1 : p*CH*8]
//   mem_we     out  write request, held until mem_ready
//   mem_ready  in   memory accepts the write when mem_we && mem_ready
//   mem_addr   out  byte address of the first byte of mem_wdata
//   mem_wdata  out  swizzled pixel bytes
//   busy       out  high while a frame is in progress (RUN or DRAIN)
//   done       out  one-cycle pulse after the final write is accepted
//   err        out  sticky flag: in_valid seen while not in RUN
// ---------------------------------------------------------------------------
module bmp_frame_writer #(
    parameter int WIDTH     = 768,
    parameter int HEIGHT    = 512,
    parameter int PPB       = 2,
    parameter int CH        = 3,
    parameter int FLIP      = 1,
    parameter int HDR_BYTES = 54,
    parameter int ADDR_W    = 21
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PPB*CH*8-1:0]   in_data,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [PPB*CH*8-1:0]   mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int DW         = PPB * CH * 8;
    localparam int COLS       = WIDTH / PPB;
    localparam int BEAT_BYTES = PPB * CH;
    // Each BMP row is rounded up to a multiple of 4 bytes.
    localparam int STRIDE     = ((WIDTH * CH + 3) / 4) * 4;
    localparam int ROW_W      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] A_HDR      = ADDR_W'(HDR_BYTES);
    localparam logic [ADDR_W-1:0] A_STRIDE   = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] A_BEAT     = ADDR_W'(BEAT_BYTES);
    localparam logic [ADDR_W-1:0] A_ROW_LAST = ADDR_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Reverse the channel order inside each pixel; pixel order is kept.
    function automatic logic [DW-1:0] swizzle(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = {DW{1'b0}};
        for (int p = 0; p < PPB; p++) begin
            for (int c = 0; c < CH; c++) begin
                r[(p*CH + c)*8 +: 8] = d[(p*CH + (CH - 1 - c))*8 +: 8];
            end
        end
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               in_ready_s;
    logic               accept_s;
    logic               wr_fire_s;
    logic               last_beat_s;
    logic [ADDR_W-1:0]  r_mem_s;
    logic [ADDR_W-1:0]  beat_addr_s;

    // Handshake decode: a new beat may enter whenever the single output
    // stage is empty or is being emptied in this very cycle.
    always_comb begin
        in_ready_s  = (state_q == ST_RUN) && (!mem_we_q || mem_ready);
        accept_s    = in_valid && in_ready_s;
        wr_fire_s   = mem_we_q && mem_ready;
        last_beat_s = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

    // Byte address of the beat at the current row / column-beat position.
    // All arithmetic is done modulo 2**ADDR_W, which is the truncation the
    // address bus needs anyway.
    always_comb begin
        if (FLIP != 0) begin
            r_mem_s = A_ROW_LAST - ADDR_W'(row_q);
        end else begin
            r_mem_s = ADDR_W'(row_q);
        end
        beat_addr_s = A_HDR + (r_mem_s * A_STRIDE) + (ADDR_W'(col_q) * A_BEAT);
    end

    // Next-state logic: FSM, position counters, output stage and flags.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        mem_we_d = mem_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    row_d   = {ROW_W{1'b0}};
                    col_d   = {COL_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    if (col_q == COL_LAST) begin
                        col_d = {COL_W{1'b0}};
                        if (row_q == ROW_LAST) begin
                            row_d = {ROW_W{1'b0}};
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    col_d = col_q;
                end
                if (accept_s && last_beat_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A start arriving together with this exit is dropped on
                // purpose: a new frame needs start while already in IDLE.
                if (wr_fire_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output stage: loading a new beat takes priority, which keeps
        // mem_we high across back-to-back writes with no bubble.
        if (accept_s) begin
            mem_we_d = 1'b1;
            addr_d   = beat_addr_s;
            wdata_d  = swizzle(in_data);
        end else if (wr_fire_s) begin
            mem_we_d = 1'b0;
        end else begin
            mem_we_d = mem_we_q;
        end

        // Beats offered outside RUN are a protocol violation; never cleared
        // except by reset.
        if (in_valid && ((state_q == ST_IDLE) || (state_q == ST_DRAIN))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            row_q    <= {ROW_W{1'b0}};
            col_q    <= {COL_W{1'b0}};
            mem_we_q <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DW{1'b0}};
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bmp_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_bmp_frame_writer
//
// Two instances of bmp_frame_writer on a shared clock:
//   dut_a : WIDTH=4, HEIGHT=2, PPB=2, CH=3, FLIP=1  (bottom-up rows)
//   dut_b : WIDTH=2, HEIGHT=3, PPB=2, CH=3, FLIP=0  (top-down, padded rows)
// A reference model builds the expected write list of a frame from plain
// address arithmetic and per-pixel byte reversal, then a cycle loop drives
// randomized traffic and compares every DUT output against the model.
// ---------------------------------------------------------------------------
module tb_bmp_frame_writer;

    localparam int DW = 48;
    localparam int AW = 21;

    logic          clk_s;
    logic          hreset_s    [2];
    logic          start_s     [2];
    logic          in_valid_s  [2];
    logic          in_ready_s  [2];
    logic [DW-1:0] in_data_s   [2];
    logic          mem_we_s    [2];
    logic          mem_ready_s [2];
    logic [AW-1:0] mem_addr_s  [2];
    logic [DW-1:0] mem_wdata_s [2];
    logic          busy_s      [2];
    logic          done_s      [2];
    logic          err_s       [2];

    int n_checks;
    int n_fail;

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    bmp_frame_writer #(
        .WIDTH(4), .HEIGHT(2), .PPB(2), .CH(3), .FLIP(1), .HDR_BYTES(54), .ADDR_W(AW)
    ) dut_a (
        .HCLK(clk_s), .HRESET(hreset_s[0]), .start(start_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
        .mem_we(mem_we_s[0]), .mem_ready(mem_ready_s[0]), .mem_addr(mem_addr_s[0]),
        .mem_wdata(mem_wdata_s[0]), .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0])
    );

    bmp_frame_writer #(
        .WIDTH(2), .HEIGHT(3), .PPB(2), .CH(3), .FLIP(0), .HDR_BYTES(54), .ADDR_W(AW)
    ) dut_b (
        .HCLK(clk_s), .HRESET(hreset_s[1]), .start(start_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
        .mem_we(mem_we_s[1]), .mem_ready(mem_ready_s[1]), .mem_addr(mem_addr_s[1]),
        .mem_wdata(mem_wdata_s[1]), .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1])
    );

    function automatic int cfg_w(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int cfg_h(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int cfg_flip(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // BGR view of a beat: each 24-bit pixel has its three bytes reversed.
    function automatic logic [DW-1:0] model_bgr(input logic [DW-1:0] d);
        logic [DW-1:0] o;
        logic [23:0]   px;
        o = d;
        for (int p = 0; p < 2; p++) begin
            px = d[p*24 +: 24];
            o[p*24 +: 24] = {px[7:0], px[15:8], px[23:16]};
        end
        return o;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Hold instance i in reset for one edge, then check the reset outputs.
    task automatic do_reset(input int i);
        hreset_s[i]    = 1'b1;
        start_s[i]     = 1'b0;
        in_valid_s[i]  = 1'b0;
        mem_ready_s[i] = 1'b1;
        @(negedge clk_s);
        hreset_s[i] = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready_s[i], 1'b0);
        check_eq("rst_mem_we", mem_we_s[i], 1'b0);
        check_eq("rst_mem_addr", mem_addr_s[i], 0);
        check_eq("rst_mem_wdata", mem_wdata_s[i], 0);
        check_eq("rst_busy", busy_s[i], 1'b0);
        check_eq("rst_done", done_s[i], 1'b0);
        check_eq("rst_err", err_s[i], 1'b0);
    endtask

    // A few quiet cycles in which nothing may happen.
    task automatic idle_check(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_s);
            start_s[i]    = 1'b0;
            in_valid_s[i] = 1'b0;
            #1;
            check_eq("idle_mem_we", mem_we_s[i], 1'b0);
            check_eq("idle_busy", busy_s[i], 1'b0);
            check_eq("idle_done", done_s[i], 1'b0);
        end
    endtask

    // One full frame. mode 0: streaming, 1: random valid/ready,
    // 2: streaming with mem_ready held low for 5 cycles early in the frame.
    task automatic run_frame(input int i, input int mode, input bit fix_pix0);
        int            cols, total, stride, row, col, rmem, a;
        int            sent, wr_done, cyc;
        logic [DW-1:0] beats[$];
        logic [AW-1:0] exp_addr[$];
        logic [DW-1:0] exp_data[$];
        logic [DW-1:0] b;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_data;
        logic          pending, v, r, exp_rdy, acc;
        bit            done_next;

        cols   = cfg_w(i) / 2;
        total  = cols * cfg_h(i);
        stride = ((cfg_w(i) * 3 + 3) / 4) * 4;
        for (int k = 0; k < total; k++) begin
            b = rand_beat();
            if (fix_pix0 && k == 0) b[23:0] = 24'h332211;
            beats.push_back(b);
            row  = k / cols;
            col  = k % cols;
            rmem = (cfg_flip(i) != 0) ? (cfg_h(i) - 1 - row) : row;
            a    = 54 + rmem * stride + col * 6;
            exp_addr.push_back(AW'(a));
            exp_data.push_back(model_bgr(b));
        end

        @(negedge clk_s);
        start_s[i]     = 1'b1;
        in_valid_s[i]  = 1'b0;
        mem_ready_s[i] = 1'b1;
        @(negedge clk_s);
        start_s[i] = 1'b0;

        pending   = 1'b0;
        sent      = 0;
        wr_done   = 0;
        done_next = 1'b0;
        cur_addr  = '0;
        cur_data  = '0;
        cyc       = 0;
        while ((wr_done < total || done_next) && cyc < 300) begin
            v = (sent < total) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (mode == 1)      r = ($urandom_range(0, 2) != 0);
            else if (mode == 2) r = !(cyc >= 1 && cyc <= 5);
            else                r = 1'b1;
            in_valid_s[i]  = v;
            in_data_s[i]   = v ? beats[sent] : rand_beat();
            mem_ready_s[i] = r;
            // start while a frame is active (including the final-write cycle)
            // must be ignored
            start_s[i] = (sent < total || pending) && ($urandom_range(0, 4) == 0);
            #1;
            exp_rdy = (sent < total) && (!pending || r);
            check_eq("in_ready", in_ready_s[i], exp_rdy);
            check_eq("mem_we", mem_we_s[i], pending);
            check_eq("busy", busy_s[i], (sent < total) || pending);
            check_eq("done", done_s[i], done_next);
            check_eq("err", err_s[i], 1'b0);
            if (pending) begin
                check_eq("mem_addr", mem_addr_s[i], cur_addr);
                check_eq("mem_wdata", mem_wdata_s[i], cur_data);
                if (fix_pix0 && wr_done == 0) begin
                    check_eq("swz_pix0", mem_wdata_s[i][23:0], 24'h112233);
                end
            end
            done_next = 1'b0;
            acc = v && exp_rdy;
            if (pending && r) begin
                wr_done++;
                if (wr_done == total) done_next = 1'b1;
            end
            if (acc) begin
                cur_addr = exp_addr[sent];
                cur_data = exp_data[sent];
                sent++;
                pending = 1'b1;
            end else if (pending && r) begin
                pending = 1'b0;
            end
            @(negedge clk_s);
            cyc++;
        end
        if (cyc >= 300) check_eq("frame_timeout", wr_done, total);
        start_s[i]    = 1'b0;
        in_valid_s[i] = 1'b0;
        #1;
        check_eq("post_mem_we", mem_we_s[i], 1'b0);
        check_eq("post_busy", busy_s[i], 1'b0);
        check_eq("post_done", done_s[i], 1'b0);
    endtask

    // in_valid while idle flags err, writes nothing and is sticky.
    task automatic err_test(input int i);
        @(negedge clk_s);
        in_valid_s[i] = 1'b1;
        in_data_s[i]  = rand_beat();
        #1;
        check_eq("err_in_ready", in_ready_s[i], 1'b0);
        @(negedge clk_s);
        in_valid_s[i] = 1'b0;
        #1;
        check_eq("err_set", err_s[i], 1'b1);
        check_eq("err_mem_we", mem_we_s[i], 1'b0);
        check_eq("err_busy", busy_s[i], 1'b0);
        @(negedge clk_s);
        #1;
        check_eq("err_sticky", err_s[i], 1'b1);
        check_eq("err_mem_we2", mem_we_s[i], 1'b0);
    endtask

    // Start a frame, push two beats, then reset with a write still pending.
    task automatic midframe_reset(input int i);
        @(negedge clk_s);
        start_s[i] = 1'b1;
        @(negedge clk_s);
        start_s[i]     = 1'b0;
        in_valid_s[i]  = 1'b1;
        in_data_s[i]   = rand_beat();
        mem_ready_s[i] = 1'b1;
        @(negedge clk_s);
        in_data_s[i] = rand_beat();
        @(negedge clk_s);
        #1;
        check_eq("mid_busy", busy_s[i], 1'b1);
        check_eq("mid_mem_we", mem_we_s[i], 1'b1);
        do_reset(i);
        idle_check(i, 3);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 2; i++) begin
            hreset_s[i]    = 1'b1;
            start_s[i]     = 1'b0;
            in_valid_s[i]  = 1'b0;
            in_data_s[i]   = '0;
            mem_ready_s[i] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            do_reset(i);
            idle_check(i, 2);
            err_test(i);
            do_reset(i);
            run_frame(i, 0, 1'b1);
            run_frame(i, 2, 1'b0);
            for (int k = 0; k < 4; k++) run_frame(i, 1, 1'b0);
            midframe_reset(i);
            run_frame(i, 0, 1'b0);
            run_frame(i, 1, 1'b0);
            hreset_s[i] = 1'b1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bmp_frame_writer.md
BMP_FRAME_WRITER -- requirements
Module: bmp_frame_writer

Interface
REQ-001 Parameter WIDTH, default 768, is the image width in pixels; WIDTH % PPB == 0 SHALL hold.
REQ-002 Parameter HEIGHT, default 512, is the image height in rows.
REQ-003 Parameter PPB, default 2, is the pixels per input beat (1, 2 or 4).
REQ-004 Parameter CH, default 3, is the bytes (channels) per pixel (1, 3 or 4).
REQ-005 Parameter FLIP, default 1: 1 stores rows bottom-up (BMP order), 0 stores them top-down.
REQ-006 Parameter HDR_BYTES, default 54, is the byte offset of pixel data from address 0.
REQ-007 Parameter ADDR_W, default 21, is the memory byte-address width.
REQ-008 The design SHALL use one clock; reset is synchronous and active-high.
REQ-009 HCLK  in  1  the clock; all state changes on its rising edge.
REQ-010 HRESET  in  1  synchronous active-high reset.
REQ-011 start  in  1  single-cycle frame start request.
REQ-012 in_valid  in  1  input beat valid.
REQ-013 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-014 in_data  in  PPB*CH*8  pixel p occupies bits [(p+1)*CH*8-1 : p*CH*8]; channel c is byte c of its pixel.
REQ-015 mem_we  out  1  write request, held until accepted.
REQ-016 mem_ready  in  1  memory accepts the write when mem_we && mem_ready.
REQ-017 mem_addr  out  ADDR_W  byte address of the first byte of mem_wdata.
REQ-018 mem_wdata  out  PPB*CH*8  swizzled pixel bytes.
REQ-019 busy  out  1  high in RUN and DRAIN.
REQ-020 done  out  1  one-cycle pulse when the final write is accepted.
REQ-021 err  out  1  sticky protocol-error flag.

Function
REQ-022 FSM states are IDLE, RUN and DRAIN; transitions are as follows.
- IDLE->RUN on start.
- RUN->DRAIN when the last beat (row HEIGHT-1, column beat WIDTH/PPB-1) is accepted.
- DRAIN->IDLE when the pending write is accepted, pulsing done in that same cycle.
REQ-023 On IDLE->RUN, the row and column-beat counters SHALL clear to 0.
REQ-024 start in RUN or DRAIN SHALL be ignored, with no counter or state change.
REQ-025 in_ready SHALL equal (state==RUN) && (!mem_we || mem_ready).
- The output register is one stage deep.
- Accepted beat n drives mem_we on the next cycle (latency 1).
REQ-026 The column-beat counter SHALL increment per accepted beat and wrap at WIDTH/PPB-1, incrementing the row counter.
REQ-027 The row stride SHALL be STRIDE = ((WIDTH*CH+3)/4)*4 bytes, computed at elaboration time.
- Padding bytes are never written.
REQ-028 The memory row SHALL be r_mem = FLIP ? HEIGHT-1-row : row.
REQ-029 mem_addr SHALL equal HDR_BYTES + r_mem*STRIDE + colbeat*PPB*CH, truncated to ADDR_W bits.
REQ-030 Swizzle rule: output byte c of pixel p SHALL be input byte CH-1-c of pixel p (RGB to BGR); pixel order is unchanged.
REQ-031 When mem_we && !mem_ready, mem_addr and mem_wdata SHALL hold stable, and in_ready SHALL be 0.
REQ-032 When mem_we && mem_ready and a new beat is accepted in the same cycle, mem_we SHALL stay 1 with the new address and data (back-to-back, no bubble).
REQ-033 err SHALL set on in_valid while in IDLE or DRAIN; it clears only on HRESET.
- The offending beat is not accepted.
REQ-034 A start in the same cycle as DRAIN->IDLE SHALL be ignored; a new frame needs start while in IDLE.

Reset
REQ-035 While HRESET=1, the block SHALL enter IDLE and drive the following, all on the next HCLK edge:
- in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
- busy=0, done=0, err=0.
- Row and column counters = 0.
REQ-036 HRESET asserted mid-frame SHALL abandon the frame; no done pulse and no further writes occur.
REQ-037 After reset release, the block SHALL stay idle until start.

Verification
REQ-038 Flip addressing: WIDTH=4, HEIGHT=2, PPB=2, CH=3, FLIP=1, mem_ready=1, 4 beats streamed -> mem_addr sequence 66, 72, 54, 60.
- done pulses once, 1 cycle after the 4th write appears.
REQ-039 Padding: WIDTH=2, HEIGHT=3, PPB=2, FLIP=0 -> STRIDE=8 and mem_addr sequence 54, 62, 70.
REQ-040 Swizzle: in_data pixel0 = bytes 0x11,0x22,0x33 -> mem_wdata pixel0 = bytes 0x33,0x22,0x11.
REQ-041 Backpressure: mem_ready held 0 for 5 cycles mid-frame -> in_ready=0 and mem_addr/mem_wdata stable throughout.
- No beat is lost or duplicated after release.
REQ-042 Protocol error and reset: in_valid=1 in IDLE -> err=1 and no mem_we.
- HRESET mid-frame, then a new start -> addresses restart at the first-row address and err=0.
